// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, word-addressed instruction
// memory and the registered IF/ID latch consumed by decode.
module if_stage #(
  parameter int          IM_DEPTH = 256,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  localparam int AW = $clog2(IM_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instruction;
    logic        valid;
  } if_id_t;

  // Preloaded hierarchically by benches; unwritten words read as nop.
  logic [31:0] ins_memory [0:IM_DEPTH-1] = '{default: '0};

  logic [AW-1:0] index;
  logic [31:0]   fetch_word;
  logic [31:0]   pc_next4;
  logic [31:0]   redirect;
  if_id_t        latch;
  if_id_t        bubble;
  if_id_t        fetched;

  assign index      = pc[AW+1:2];
  assign fetch_word = ins_memory[index];
  assign pc_next4   = pc + 32'd4;
  assign redirect   = branch_target & 32'hFFFF_FFFC;

  assign bubble  = '0;
  assign fetched = '{
    pc:          pc,
    pc_plus4:    pc_next4,
    instruction: fetch_word,
    valid:       1'b1
  };

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      latch       <= '0;
      fetch_count <= '0;
    end else if (branch_taken) begin
      pc    <= redirect;
      latch <= bubble;
    end else if (flush) begin
      latch <= bubble;
      if (!stall)
        pc <= pc_next4;
    end else if (!stall) begin
      pc          <= pc_next4;
      latch       <= fetched;
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign if_id_pc          = latch.pc;
  assign if_id_pc_plus4    = latch.pc_plus4;
  assign if_id_instruction = latch.instruction;
  assign if_id_valid       = latch.valid;

endmodule
